// File: rtl/mmio_hub.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : mmio_hub                                                         |
// | Purpose  : Memory-mapped I/O hub between the CPU data port and the board   |
// |            peripherals. Local registers: LED (0x0), SW (0x1), SW_CHG (0x2, |
// |            sticky, W1C), STATUS (0x3: bit0 bus_err, bit1 irq). From 0x4 on,|
// |            N_PERIPH windows of PERIPH_SPAN words are served via a          |
// |            select/ack handshake that stalls the CPU, with a timeout.       |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            mm_we, mm_re, addr, wdata -> rdata, stall      (CPU side)       |
// |            sw -> led, irq                                 (board I/O)      |
// |            p_sel, p_we, p_addr, p_wdata <- p_rdata, p_ack (peripherals)    |
// | Revision : 1.0 - initial release                                           |
// +-----------------------------------------------------------------------------+
module mmio_hub #(
   parameter logic [15:0] BASE_ADDR   = 16'hC000,
   parameter int          LED_W       = 10,
   parameter int          SW_W        = 10,
   parameter int          N_PERIPH    = 4,
   parameter int          PERIPH_SPAN = 4,
   parameter int          TIMEOUT_CYC = 255
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           mm_we,
   input  logic                           mm_re,
   input  logic [15:0]                    addr,
   input  logic [15:0]                    wdata,
   output logic [15:0]                    rdata,
   output logic                           stall,
   input  logic [SW_W-1:0]                sw,
   output logic [LED_W-1:0]               led,
   output logic                           irq,
   output logic [N_PERIPH-1:0]            p_sel,
   output logic                           p_we,
   output logic [$clog2(PERIPH_SPAN)-1:0] p_addr,
   output logic [15:0]                    p_wdata,
   input  logic [15:0]                    p_rdata,
   input  logic                           p_ack
);

   localparam int          c_AW      = $clog2(PERIPH_SPAN);
   localparam int          c_CH_W    = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
   localparam logic [15:0] c_LIMIT   = 16'(4 + N_PERIPH * PERIPH_SPAN);
   localparam logic [7:0]  c_TO_LAST = 8'(TIMEOUT_CYC - 1);
   localparam logic [15:0] c_IDLE_RD = 16'hA5A5;
   localparam logic [15:0] c_ERR_RD  = 16'hDEAD;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic                w_stall;

   logic [LED_W-1:0]    r_led;
   logic [SW_W-1:0]     r_sw_meta, r_sw_sync, r_sw_prev, r_sw_chg;
   logic                r_bus_err;
   logic [7:0]          r_cnt;
   logic [c_CH_W-1:0]   r_ch;
   logic [c_AW-1:0]     r_paddr;
   logic                r_we;
   logic [15:0]         r_wdata;
   logic [15:0]         r_rd_hold;

   // ---------------------------------------------------------------- decode
   logic [15:0]         w_off, w_win_off, w_ch_full;
   logic                w_in_space, w_local, w_window, w_win_acc;
   logic                w_wr_led, w_wr_chg, w_wr_status;
   logic                w_timeout;
   logic [SW_W-1:0]     w_chg_clr;
   logic                w_unused_ch;

   assign w_off       = addr - BASE_ADDR;
   // The >= test matters: below BASE_ADDR the subtraction wraps to a large
   // offset, but near 16'hFFFF a tiny map could otherwise alias.
   assign w_in_space  = (addr >= BASE_ADDR) && (w_off < c_LIMIT);
   assign w_local     = w_in_space && (w_off < 16'd4);
   assign w_window    = w_in_space && !w_local;
   assign w_win_acc   = w_window && (mm_we || mm_re);
   assign w_win_off   = w_off - 16'd4;
   assign w_ch_full   = w_win_off >> c_AW;
   assign w_unused_ch = &{1'b0, w_ch_full[15:c_CH_W]};

   assign w_wr_led    = mm_we && w_local && (w_off[1:0] == 2'd0);
   assign w_wr_chg    = mm_we && w_local && (w_off[1:0] == 2'd2);
   assign w_wr_status = mm_we && w_local && (w_off[1:0] == 2'd3);
   assign w_chg_clr   = w_wr_chg ? wdata[SW_W-1:0] : '0;

   // Counter holds (BUSY cycle - 1), so the last permitted BUSY cycle is
   // the one where it equals TIMEOUT_CYC-1.
   assign w_timeout   = (r_cnt == c_TO_LAST);

   // ------------------------------------------------------- local registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_led     <= '0;
         r_sw_meta <= '0;
         r_sw_sync <= '0;
         r_sw_prev <= '0;
         r_sw_chg  <= '0;
      end else begin
         if (w_wr_led) begin
            r_led <= wdata[LED_W-1:0];
         end
         r_sw_meta <= sw;
         r_sw_sync <= r_sw_meta;
         r_sw_prev <= r_sw_sync;
         // Set after clear so a same-cycle edge survives the W1C.
         r_sw_chg  <= (r_sw_chg & ~w_chg_clr) | (r_sw_sync ^ r_sw_prev);
      end
   end

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_win_acc) begin
               w_stall     = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            w_stall = 1'b1;
            if (p_ack || w_timeout) begin
               w_state_nxt = S_DONE;
            end
         end
         // DONE releases the CPU for one cycle and always falls back to
         // IDLE, so the strobe still present here cannot relaunch.
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------ window datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ch      <= '0;
         r_paddr   <= '0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
         r_cnt     <= '0;
         r_rd_hold <= '0;
         r_bus_err <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_win_acc) begin
            r_ch    <= w_ch_full[c_CH_W-1:0];
            r_paddr <= w_win_off[c_AW-1:0];
            r_we    <= mm_we;
            r_wdata <= wdata;
         end

         r_cnt <= (r_state == S_BUSY) ? r_cnt + 8'd1 : 8'd0;

         // An ack in the timeout cycle wins: no error, real data returned.
         if (r_state == S_BUSY) begin
            if (p_ack) begin
               r_rd_hold <= p_rdata;
            end else if (w_timeout) begin
               r_rd_hold <= c_ERR_RD;
            end
         end

         if (r_state == S_BUSY && !p_ack && w_timeout) begin
            r_bus_err <= 1'b1;
         end else if (w_wr_status) begin
            r_bus_err <= 1'b0;
         end
      end
   end

   // -------------------------------------------------------------- outputs
   assign stall   = w_stall;
   assign led     = r_led;
   assign irq     = |r_sw_chg;
   assign p_sel   = (r_state == S_BUSY) ? (N_PERIPH'(1) << r_ch) : '0;
   assign p_we    = r_we;
   assign p_addr  = r_paddr;
   assign p_wdata = r_wdata;

   always_comb begin
      rdata = c_IDLE_RD;
      if (w_local) begin
         case (w_off[1:0])
            2'd0:    rdata = 16'(r_led);
            2'd1:    rdata = 16'(r_sw_sync);
            2'd2:    rdata = 16'(r_sw_chg);
            default: rdata = {14'd0, irq, r_bus_err};
         endcase
      end else if (r_state == S_DONE) begin
         rdata = r_rd_hold;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mmio_hub.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_mmio_hub                                                      |
// | Purpose  : Self-checking bench for mmio_hub (TIMEOUT_CYC = 8). Local       |
// |            register vectors from a table, switch sync / W1C sequences,    |
// |            peripheral windows against a responder model, timeout and      |
// |            reset-in-BUSY. Read data goes through an expected-value queue. |
// | Revision : 1.0 - initial release                                           |
// +-----------------------------------------------------------------------------+
module tb_mmio_hub;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mm_we, mm_re;
   logic [15:0] addr, wdata;
   logic [15:0] rdata;
   logic        stall;
   logic [9:0]  sw;
   logic [9:0]  led;
   logic        irq;
   logic [3:0]  p_sel;
   logic        p_we;
   logic [1:0]  p_addr;
   logic [15:0] p_wdata;
   logic [15:0] p_rdata;
   logic        p_ack;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];

   // Responder configuration: ack in BUSY cycle ack_k (0 = never).
   int          ack_k    = 0;
   logic [15:0] ack_data = 16'h0;
   int          pcnt     = 0;

   always #5 clk = ~clk;

   mmio_hub #(
      .BASE_ADDR  (16'hC000),
      .LED_W      (10),
      .SW_W       (10),
      .N_PERIPH   (4),
      .PERIPH_SPAN(4),
      .TIMEOUT_CYC(8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .mm_we  (mm_we),
      .mm_re  (mm_re),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .stall  (stall),
      .sw     (sw),
      .led    (led),
      .irq    (irq),
      .p_sel  (p_sel),
      .p_we   (p_we),
      .p_addr (p_addr),
      .p_wdata(p_wdata),
      .p_rdata(p_rdata),
      .p_ack  (p_ack)
   );

   // Peripheral responder: counts cycles with a select active and raises
   // ack mid-cycle so it is stable at the next rising edge.
   initial begin
      p_ack   = 1'b0;
      p_rdata = 16'h0BAD;
      forever begin
         @(negedge clk);
         if (p_sel != 4'b0000) begin
            pcnt    = pcnt + 1;
            p_ack   = (ack_k != 0) && (pcnt == ack_k);
            p_rdata = p_ack ? ack_data : 16'h0BAD;
         end else begin
            pcnt    = 0;
            p_ack   = 1'b0;
            p_rdata = 16'h0BAD;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One local/unmapped access, entered and left at posedge+1.
   task automatic local_acc(input logic we, input logic re, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] exp_rd,
                            input logic [9:0] exp_led);
      logic [15:0] e;
      mm_we = we; mm_re = re; addr = a; wdata = d;
      if (re) exp_q.push_back(exp_rd);
      @(negedge clk);
      check("local_stall", stall, 0);
      if (re) begin
         e = exp_q.pop_front();
         check("local_rdata", rdata, e);
      end
      @(posedge clk); #1;
      mm_we = 1'b0; mm_re = 1'b0;
      check("led", led, exp_led);
   endtask

   // One window access; exp_stall total stall cycles, select lasts one less.
   task automatic win_acc(input logic we, input logic [15:0] a, input logic [15:0] d,
                          input int k, input logic [15:0] ad, input logic [15:0] exp_rd,
                          input logic [3:0] exp_sel, input logic [1:0] exp_pa,
                          input int exp_stall);
      int          st = 0;
      int          sc = 0;
      bit          done = 0;
      logic [15:0] e;
      ack_k = k; ack_data = ad;
      mm_we = we; mm_re = !we; addr = a; wdata = d;
      if (!we) exp_q.push_back(exp_rd);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1;
            break;
         end
         st++;
         if (p_sel != 4'b0000) begin
            sc++;
            check("p_sel", p_sel, exp_sel);
            check("p_addr", p_addr, exp_pa);
            check("p_we", p_we, we);
            if (we) check("p_wdata", p_wdata, d);
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL win_wait: stall still high after 300 cycles, required release");
      end
      if (!we) begin
         e = exp_q.pop_front();
         check("win_rdata", rdata, e);
      end
      check("stall_cycles", st, exp_stall);
      check("sel_cycles", sc, exp_stall - 1);
      check("done_psel", p_sel, 0);
      @(posedge clk); #1;
      mm_we = 1'b0; mm_re = 1'b0; ack_k = 0;
   endtask

   typedef struct {
      logic        we;
      logic        re;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
      logic [9:0]  exp_led;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 1'b0, 16'hC000, 16'h03FF, 16'h0000, 10'h3FF};
      vecs[1] = '{1'b0, 1'b1, 16'hC000, 16'h0000, 16'h03FF, 10'h3FF};
      vecs[2] = '{1'b0, 1'b1, 16'hBFFF, 16'h0000, 16'hA5A5, 10'h3FF};
      vecs[3] = '{1'b0, 1'b1, 16'hC014, 16'h0000, 16'hA5A5, 10'h3FF};
      vecs[4] = '{1'b0, 1'b1, 16'hC003, 16'h0000, 16'h0000, 10'h3FF};
      vecs[5] = '{1'b0, 1'b1, 16'hC001, 16'h0000, 16'h0000, 10'h3FF};
      vecs[6] = '{1'b1, 1'b0, 16'hC000, 16'h1234, 16'h0000, 10'h234};
      vecs[7] = '{1'b0, 1'b1, 16'hC000, 16'h0000, 16'h0234, 10'h234};
      vecs[8] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hA5A5, 10'h234};
      vecs[9] = '{1'b1, 1'b0, 16'hC000, 16'h02AA, 16'h0000, 10'h2AA};

      rst_n = 1'b0; mm_we = 1'b0; mm_re = 1'b0;
      addr = 16'h0000; wdata = 16'h0000; sw = 10'h000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_led", led, 0);
      check("rst_psel", p_sel, 0);
      check("rst_pwe", p_we, 0);
      check("rst_paddr", p_addr, 0);
      check("rst_pwdata", p_wdata, 0);
      check("rst_stall", stall, 0);
      check("rst_irq", irq, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Local registers and unmapped decode
      for (int i = 0; i < 10; i++) begin
         local_acc(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rd, vecs[i].exp_led);
      end

      // Switch synchroniser latency and change detection
      sw = 10'h008; mm_re = 1'b1; addr = 16'hC001;
      @(negedge clk); check("sw_lat0", rdata, 16'h0000);
      @(negedge clk); check("sw_lat1", rdata, 16'h0000);
      @(negedge clk); check("sw_read", rdata, 16'h0008);
      check("irq_early", irq, 0);
      @(negedge clk); check("irq_set", irq, 1);
      @(posedge clk); #1;
      mm_re = 1'b0;
      local_acc(1'b0, 1'b1, 16'hC003, 16'h0000, 16'h0002, 10'h2AA);
      local_acc(1'b1, 1'b0, 16'hC002, 16'h0008, 16'h0000, 10'h2AA);
      check("irq_clr", irq, 0);

      // Set and W1C on the same bit in the same cycle: set wins
      sw = 10'h000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mm_we = 1'b1; addr = 16'hC002; wdata = 16'h0008;
      @(posedge clk); #1;
      mm_we = 1'b0;
      check("set_wins_irq", irq, 1);
      local_acc(1'b0, 1'b1, 16'hC002, 16'h0000, 16'h0008, 10'h2AA);
      local_acc(1'b1, 1'b0, 16'hC002, 16'h0008, 16'h0000, 10'h2AA);
      check("irq_clr2", irq, 0);

      // Peripheral windows
      win_acc(1'b0, 16'hC005, 16'h0000, 3, 16'h0041, 16'h0041, 4'b0001, 2'd1, 4);
      win_acc(1'b1, 16'hC00A, 16'h0012, 1, 16'h0000, 16'h0000, 4'b0010, 2'd2, 2);
      win_acc(1'b0, 16'hC013, 16'h0000, 2, 16'hBEEF, 16'hBEEF, 4'b1000, 2'd3, 3);
      local_acc(1'b0, 1'b1, 16'hC003, 16'h0000, 16'h0000, 10'h2AA);

      // Timeout, then clear of bus_err
      win_acc(1'b0, 16'hC008, 16'h0000, 0, 16'h0000, 16'hDEAD, 4'b0010, 2'd0, 9);
      local_acc(1'b0, 1'b1, 16'hC003, 16'h0000, 16'h0001, 10'h2AA);
      local_acc(1'b1, 1'b0, 16'hC003, 16'h1234, 16'h0000, 10'h2AA);
      local_acc(1'b0, 1'b1, 16'hC003, 16'h0000, 16'h0000, 10'h2AA);

      // Ack in the timeout cycle wins over the error
      win_acc(1'b0, 16'hC00F, 16'h0000, 8, 16'h1111, 16'h1111, 4'b0100, 2'd3, 9);
      local_acc(1'b0, 1'b1, 16'hC003, 16'h0000, 16'h0000, 10'h2AA);

      // Reset in the middle of BUSY
      ack_k = 0; mm_re = 1'b1; addr = 16'hC006;
      repeat (3) @(negedge clk);
      #1;
      check("busy_psel", p_sel, 4'b0001);
      rst_n = 1'b0; mm_re = 1'b0;
      #1;
      check("rstbusy_psel", p_sel, 0);
      check("rstbusy_stall", stall, 0);
      check("rstbusy_led", led, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      local_acc(1'b0, 1'b1, 16'hC003, 16'h0000, 16'h0000, 10'h000);
      local_acc(1'b0, 1'b1, 16'hC000, 16'h0000, 16'h0000, 10'h000);
      local_acc(1'b0, 1'b1, 16'hBFFF, 16'h0000, 16'hA5A5, 10'h000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
